// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that frames one requester's 16-bit word into a byte stream for a shared UART transmitter.
// Optional feature macro UART_ARB_CHECKSUM_EN: appends an XOR checksum byte (5-byte frames instead of 4).
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter logic [7:0]  HEADER  = 8'hA5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arb_en,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic                   busy,
    output logic [3:0]             cur_src
);

`ifdef UART_ARB_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT
    } state_t;

    state_t      state_reg;
    logic [3:0]  last_grant_reg;
    logic [2:0]  idx_reg;
    logic [15:0] word_reg;

    logic [NUM_REQ-1:0] req_rot;
    logic [NUM_REQ:0]   seen;
    logic [3:0]         win_acc  [NUM_REQ+1];
    logic [15:0]        data_acc [NUM_REQ+1];
    logic [3:0]         grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic [15:0]        grant_word;
    logic [7:0]         byte_sel;

    // Rotate requests so bit 0 is the source just after the last grant; first set bit wins.
    assign req_rot = NUM_REQ'({req, req} >> ({1'b0, last_grant_reg} + 5'd1));

    assign seen[0]     = 1'b0;
    assign win_acc[0]  = 4'd0;
    assign data_acc[0] = 16'd0;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rr
        logic [4:0] sum;
        logic [3:0] cand;
        logic       pick;

        assign sum  = {1'b0, last_grant_reg} + 5'(gi + 1);
        assign cand = (sum >= 5'(NUM_REQ)) ? 4'(sum - 5'(NUM_REQ)) : sum[3:0];
        assign pick = req_rot[gi] & ~seen[gi];

        assign seen[gi+1]    = seen[gi] | req_rot[gi];
        assign win_acc[gi+1] = win_acc[gi] | ({4{pick}} & cand);
    end

    assign grant_idx = win_acc[NUM_REQ];
    assign grant_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
        assign data_acc[gi+1] = data_acc[gi] | (req_data[16*gi +: 16] & {16{grant_oh[gi]}});
    end

    assign grant_word = data_acc[NUM_REQ];

`ifdef UART_ARB_CHECKSUM_EN
    logic [7:0] chk;
    assign chk = {4'h0, cur_src} ^ word_reg[15:8] ^ word_reg[7:0];
`endif

    always_comb begin
        byte_sel = HEADER;
        case (idx_reg)
            3'd0:    byte_sel = HEADER;
            3'd1:    byte_sel = {4'h0, cur_src};
            3'd2:    byte_sel = word_reg[15:8];
            3'd3:    byte_sel = word_reg[7:0];
`ifdef UART_ARB_CHECKSUM_EN
            3'd4:    byte_sel = chk;
`endif
            default: byte_sel = HEADER;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 4'(NUM_REQ - 1);
            idx_reg        <= 3'd0;
            word_reg       <= 16'd0;
            req_ack        <= '0;
            tx_start       <= 1'b0;
            tx_data        <= 8'h00;
            busy           <= 1'b0;
            cur_src        <= 4'd0;
        end else begin
            req_ack  <= '0;
            tx_start <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (arb_en && (|req)) begin
                        req_ack   <= grant_oh;
                        word_reg  <= grant_word;
                        cur_src   <= grant_idx;
                        idx_reg   <= 3'd0;
                        busy      <= 1'b1;
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tx_start  <= 1'b1;
                    tx_data   <= byte_sel;
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        if (idx_reg == LAST_IDX) begin
                            // Pointer only moves once the frame is fully delivered.
                            last_grant_reg <= cur_src;
                            busy           <= 1'b0;
                            state_reg      <= ST_IDLE;
                        end else begin
                            idx_reg   <= idx_reg + 3'd1;
                            state_reg <= ST_LOAD;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: byte scoreboard, transmitter model, table vectors and corner sequences.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int DONE_LAT = 20;
`ifdef UART_ARB_CHECKSUM_EN
    localparam int FRAME_LEN = 5;
`else
    localparam int FRAME_LEN = 4;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  arb_en;
    logic [NUM_REQ-1:0]    req;
    logic [16*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ack;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic                  tx_done;
    logic                  busy;
    logic [3:0]            cur_src;

    logic model_done = 1'b0;
    logic spur_done  = 1'b0;
    assign tx_done = model_done | spur_done;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .HEADER(8'hA5)) dut (
        .clk      (clk),
        .reset    (reset),
        .arb_en   (arb_en),
        .req      (req),
        .req_data (req_data),
        .req_ack  (req_ack),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .busy     (busy),
        .cur_src  (cur_src)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [3:0] ack_q[$];
    int cyc = 0, done_cnt = 0, n_starts = 0, n_dones = 0, n_acks = 0;
    int ack_cyc = 0, done_cyc = -100, ack_gap = 0;
    logic prev_start = 1'b0, prev_ack_any = 1'b0, prev_busy = 1'b0, ack_prev_busy = 1'b0;
    bit first_byte = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Transmitter model plus output monitor, sampled 1ns after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!reset) begin
            done_cnt     = 0;
            model_done   = 1'b0;
            prev_start   = 1'b0;
            prev_ack_any = 1'b0;
            prev_busy    = 1'b0;
            first_byte   = 1'b0;
        end else begin
            model_done = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    model_done = 1'b1;
                    n_dones++;
                    done_cyc = cyc;
                end
            end
            if (req_ack != '0) begin
                check("ack_not_back_to_back", prev_ack_any, 0);
                ack_q.push_back(req_ack);
                n_acks++;
                ack_gap       = cyc - done_cyc;
                ack_prev_busy = prev_busy;
                ack_cyc       = cyc;
                first_byte    = 1'b1;
            end
            if (tx_start) begin
                n_starts++;
                check("start_not_back_to_back", prev_start, 0);
                check("busy_during_start", busy, 1);
                if (first_byte) check("header_latency", cyc - ack_cyc, 1);
                else            check("byte_latency", cyc - done_cyc, 2);
                first_byte = 1'b0;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL tx_byte: unexpected tx_start with data %h, required no byte", tx_data);
                end else begin
                    check("tx_byte", tx_data, exp_q.pop_front());
                end
                done_cnt = DONE_LAT;
            end
            prev_start   = tx_start;
            prev_ack_any = |req_ack;
            prev_busy    = busy;
        end
    end

    task automatic push_frame(input logic [3:0] src, input logic [15:0] w);
        logic [7:0] sb;
        sb = {4'h0, src};
        exp_q.push_back(8'hA5);
        exp_q.push_back(sb);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
        if (FRAME_LEN == 5) exp_q.push_back(sb ^ w[15:8] ^ w[7:0]);
    endtask

    task automatic wait_ack(input logic [3:0] exp, input string nm);
        int t;
        t = 0;
        while (ack_q.size() == 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (ack_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no req_ack within 400 cycles, required %b", nm, exp);
        end else begin
            check(nm, ack_q.pop_front(), exp);
        end
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check({nm, "_busy_drop"}, busy, 0);
        check({nm, "_bytes_left"}, exp_q.size(), 0);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [15:0] data;
        logic [3:0]  exp_ack;
        bit          clobber;
        bit          spur;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int src;
        int drive_cyc;
        int t;
        int base_acks;
        int base_starts;
        int base_dones;
        logic [3:0] e;

        vecs[0] = '{4'b0010, 16'h1234, 4'b0010, 1'b0, 1'b0};
        vecs[1] = '{4'b0001, 16'hBEEF, 4'b0001, 1'b0, 1'b0};
        vecs[2] = '{4'b1000, 16'h00FF, 4'b1000, 1'b0, 1'b1};
        vecs[3] = '{4'b0100, 16'h8001, 4'b0100, 1'b0, 1'b0};
        vecs[4] = '{4'b1011, 16'h5A3C, 4'b1000, 1'b1, 1'b0};
        vecs[5] = '{4'b0110, 16'h0F0F, 4'b0010, 1'b0, 1'b1};
        vecs[6] = '{4'b0101, 16'hA55A, 4'b0100, 1'b0, 1'b0};
        vecs[7] = '{4'b0011, 16'h7E81, 4'b0001, 1'b1, 1'b0};

        reset = 1'b1; arb_en = 1'b0; req = '0; req_data = '0;
        #1 reset = 1'b0;
        #3;
        check("rst_req_ack", req_ack, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_cur_src", cur_src, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        arb_en = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            src = 0;
            for (int j = 0; j < NUM_REQ; j++) if (vecs[v].exp_ack[j]) src = j;
            for (int i = 0; i < NUM_REQ; i++)
                req_data[16*i +: 16] = (i == src) ? vecs[v].data : ~vecs[v].data;
            if (vecs[v].spur) begin
                spur_done = 1'b1;
                @(negedge clk);
                spur_done = 1'b0;
            end
            push_frame(4'(src), vecs[v].data);
            req = vecs[v].req;
            drive_cyc = cyc;
            wait_ack(vecs[v].exp_ack, "vec_ack");
            check("vec_ack_latency", ack_cyc - drive_cyc, 1);
            check("vec_busy_at_ack", busy, 1);
            check("vec_cur_src", cur_src, src);
            if (vecs[v].spur) spur_done = 1'b1;
            req = '0;
            if (vecs[v].clobber) req_data[16*src +: 16] = 16'hFFFF;
            @(negedge clk);
            spur_done = 1'b0;
            wait_idle("vec");
            $display("vector %0d: req %b -> src %0d word %h", v, vecs[v].req, src, vecs[v].data);
            @(negedge clk);
        end

        // Fairness: all sources held from reset.
        reset = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) req_data[16*i +: 16] = 16'(16'hC0D0 + i);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 6; k++) push_frame(4'(k % 4), 16'(16'hC0D0 + (k % 4)));
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            e = 4'b0001 << (k % 4);
            wait_ack(e, "fair_ack");
            check("fair_cur_src", cur_src, k % 4);
            if (k > 0) begin
                check("fair_gap_done_to_ack", ack_gap, 2);
                check("fair_busy_low_before_ack", ack_prev_busy, 0);
            end
            $display("fairness grant %0d: src %0d", k, k % 4);
        end
        req = '0;
        wait_idle("fair");
        @(negedge clk);

        // Enable gating.
        arb_en = 1'b0;
        req = 4'b1111;
        base_acks = n_acks;
        base_starts = n_starts;
        repeat (200) @(negedge clk);
        check("gated_no_ack", n_acks - base_acks, 0);
        check("gated_no_start", n_starts - base_starts, 0);
        $display("gating: 200 cycles with arb_en low");
        push_frame(4'd2, 16'hC0D2);
        arb_en = 1'b1;
        wait_ack(4'b0100, "gate_ack");
        t = 0;
        while (n_starts - base_starts < 2 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("gate_two_starts_seen", (n_starts - base_starts) >= 2, 1);
        arb_en = 1'b0;
        wait_idle("gate");
        repeat (100) @(negedge clk);
        check("gate_single_grant", n_acks - base_acks, 1);
        check("gate_frame_bytes", n_starts - base_starts, FRAME_LEN);
        $display("gating: frame from src 2 completed after arb_en drop");
        req = '0;
        arb_en = 1'b1;
        @(negedge clk);

        // Reset in the middle of a frame.
        base_dones = n_dones;
        push_frame(4'd2, 16'hC0D2);
        req = 4'b0100;
        wait_ack(4'b0100, "mid_ack");
        req = '0;
        t = 0;
        while (n_dones - base_dones < 3 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("mid_three_dones", n_dones - base_dones, 3);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_req_ack", req_ack, 0);
        check("mid_rst_tx_start", tx_start, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cur_src", cur_src, 0);
        repeat (5) @(negedge clk);
        check("mid_rst_hold_start", tx_start, 0);
        exp_q.delete();
        ack_q.delete();
        $display("mid-frame reset: partial frame of src 2 abandoned");
        base_starts = n_starts;
        reset = 1'b1;
        req = 4'b1000;
        push_frame(4'd3, 16'hC0D3);
        drive_cyc = cyc;
        wait_ack(4'b1000, "post_rst_ack");
        check("post_rst_ack_latency", ack_cyc - drive_cyc, 1);
        req = '0;
        wait_idle("post_rst");
        check("post_rst_frame_bytes", n_starts - base_starts, FRAME_LEN);
        $display("post-reset frame: src 3 word c0d3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
